// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer for the MIPS32 CP0 block: detects IRQ/SYSCALL/ERET at MEM,
// walks the EPC/Cause/Status writes over the shared CP0 write port, then flushes and redirects.
module exc_sequencer #(
    parameter logic [31:0] VECTOR_OFFSET = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        inst_valid,
    input  logic        exc_syscall,
    input  logic        exc_eret,
    input  logic [31:0] exc_pc,
    input  logic        in_delay_slot,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        stall,
    output logic        flush,
    output logic        new_pc_valid,
    output logic [31:0] new_pc
);

    localparam logic [4:0] AddrStatus = 5'd12;
    localparam logic [4:0] AddrCause  = 5'd13;
    localparam logic [4:0] AddrEpc    = 5'd14;

    typedef enum logic [2:0] {StIdle, StWEpc, StWCause, StWStatus, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic        bd_q;
    logic [4:0]  code_q;
    logic        eret_q;
    logic        epc_run_q;

    logic int_pend, sys_ev, eret_ev, exc_ev, event_det;
    logic cause_bd;
    logic unused_cause;

    assign unused_cause = ^cp0_cause[6:0];

    assign int_pend  = inst_valid & cp0_status[0] & ~cp0_status[1]
                       & (|(hw_int & cp0_status[15:10]));
    assign sys_ev    = inst_valid & exc_syscall;
    assign eret_ev   = inst_valid & exc_eret;
    assign exc_ev    = int_pend | sys_ev;
    assign event_det = exc_ev | eret_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Event context is captured once in IDLE; later re-presentations while stalled are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= 32'd0;
            bd_q      <= 1'b0;
            code_q    <= 5'd0;
            eret_q    <= 1'b0;
            epc_run_q <= 1'b0;
        end else if (state_q == StIdle && event_det) begin
            pc_q      <= exc_pc;
            bd_q      <= in_delay_slot;
            code_q    <= int_pend ? 5'd0 : 5'd8;
            eret_q    <= ~exc_ev;
            epc_run_q <= exc_ev & ~cp0_status[1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (exc_ev) begin
                    state_d = cp0_status[1] ? StWCause : StWEpc;
                end else if (eret_ev) begin
                    state_d = StWStatus;
                end
            end
            StWEpc:     state_d = StWCause;
            StWCause:   state_d = StWStatus;
            StWStatus:  state_d = StRedirect;
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Nested exceptions skip EPC, so BD must keep whatever Cause already holds.
    assign cause_bd = epc_run_q ? bd_q : cp0_cause[31];

    always_comb begin
        cp0_we       = 1'b0;
        cp0_waddr    = 5'd0;
        cp0_wdata    = 32'd0;
        stall        = 1'b0;
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = 32'd0;
        case (state_q)
            StIdle: begin
                if (event_det) begin
                    stall = 1'b1;
                end else begin
                    cp0_we    = mtc0_we;
                    cp0_waddr = mtc0_addr;
                    cp0_wdata = mtc0_data;
                end
            end
            StWEpc: begin
                stall     = 1'b1;
                cp0_we    = 1'b1;
                cp0_waddr = AddrEpc;
                cp0_wdata = bd_q ? pc_q - 32'd4 : pc_q;
            end
            StWCause: begin
                stall     = 1'b1;
                cp0_we    = 1'b1;
                cp0_waddr = AddrCause;
                cp0_wdata = {cause_bd, cp0_cause[30:7], code_q, 2'b00};
            end
            StWStatus: begin
                stall     = 1'b1;
                cp0_we    = 1'b1;
                cp0_waddr = AddrStatus;
                cp0_wdata = eret_q ? (cp0_status & ~32'h2) : (cp0_status | 32'h2);
            end
            StRedirect: begin
                stall        = 1'b1;
                flush        = 1'b1;
                new_pc_valid = 1'b1;
                new_pc       = eret_q ? cp0_epc : cp0_ebase + VECTOR_OFFSET;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: randomized events checked against a model that lists
// the expected per-cycle port activity (stall, CP0 writes, redirect) for each event.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic        inst_valid, exc_syscall, exc_eret, in_delay_slot;
    logic [31:0] exc_pc;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_ebase;
    logic        cp0_we, stall, flush, new_pc_valid;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata, new_pc;

    typedef logic [72:0] vec_t;
    localparam vec_t STALL_ONLY = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};

    vec_t exp_q[$];
    vec_t obs;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .hw_int       (hw_int),
        .inst_valid   (inst_valid),
        .exc_syscall  (exc_syscall),
        .exc_eret     (exc_eret),
        .exc_pc       (exc_pc),
        .in_delay_slot(in_delay_slot),
        .mtc0_we      (mtc0_we),
        .mtc0_addr    (mtc0_addr),
        .mtc0_data    (mtc0_data),
        .cp0_status   (cp0_status),
        .cp0_cause    (cp0_cause),
        .cp0_epc      (cp0_epc),
        .cp0_ebase    (cp0_ebase),
        .cp0_we       (cp0_we),
        .cp0_waddr    (cp0_waddr),
        .cp0_wdata    (cp0_wdata),
        .stall        (stall),
        .flush        (flush),
        .new_pc_valid (new_pc_valid),
        .new_pc       (new_pc)
    );

    assign obs = {cp0_we, cp0_waddr, cp0_wdata, stall, flush, new_pc_valid, new_pc};

    function automatic vec_t wr(input logic [4:0] a, input logic [31:0] d);
        return {1'b1, a, d, 1'b1, 1'b0, 1'b0, 32'd0};
    endfunction

    function automatic vec_t redir(input logic [31:0] t);
        return {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, t};
    endfunction

    // Reference: list of per-cycle outputs from the detection cycle to the redirect cycle.
    function automatic void build_expected();
        logic ip, sc, er, bd;
        logic [4:0] code;
        exp_q.delete();
        ip = inst_valid && cp0_status[0] && !cp0_status[1]
             && ((hw_int & cp0_status[15:10]) != 6'd0);
        sc = inst_valid && exc_syscall;
        er = inst_valid && exc_eret;
        if (ip || sc) begin
            code = ip ? 5'd0 : 5'd8;
            bd   = cp0_status[1] ? cp0_cause[31] : in_delay_slot;
            exp_q.push_back(STALL_ONLY);
            if (!cp0_status[1])
                exp_q.push_back(wr(5'd14, in_delay_slot ? exc_pc - 32'd4 : exc_pc));
            exp_q.push_back(wr(5'd13, {bd, cp0_cause[30:7], code, 2'b00}));
            exp_q.push_back(wr(5'd12, cp0_status | 32'h2));
            exp_q.push_back(redir(cp0_ebase + 32'h180));
        end else if (er) begin
            exp_q.push_back(STALL_ONLY);
            exp_q.push_back(wr(5'd12, cp0_status & ~32'h2));
            exp_q.push_back(redir(cp0_epc));
        end else begin
            exp_q.push_back({mtc0_we, mtc0_addr, mtc0_data, 3'b000, 32'd0});
        end
    endfunction

    task automatic idle_inputs();
        inst_valid = 1'b0; exc_syscall = 1'b0; exc_eret = 1'b0; hw_int = 6'd0;
        in_delay_slot = 1'b0; mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_data = 32'd0;
    endtask

    task automatic mtc0_noise();
        mtc0_we = 1'($urandom_range(0, 1)); mtc0_addr = 5'($urandom); mtc0_data = $urandom;
    endtask

    task automatic rand_cp0();
        cp0_status = $urandom; cp0_cause = $urandom; cp0_epc = $urandom; cp0_ebase = $urandom;
        exc_pc = $urandom; in_delay_slot = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rand_cp0();
        in_delay_slot = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 73'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, 73'd0);
        end
        mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'h1000_FC01;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd12, 32'h1000_FC01, 3'b000, 32'd0}) begin
            failures++; $display("FAIL mtc0_direct got=%h", obs);
        end
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_mtc0_passthrough();
        for (int k = 0; k < 10; k++) begin
            rand_cp0();
            mtc0_noise();
            inst_valid = 1'($urandom_range(0, 1));
            cp0_status[0] = 1'b0;
            build_expected();
            @(negedge clk);
            checks++;
            if (obs !== exp_q[0]) begin
                failures++; $display("FAIL mtc0_pass k=%0d got=%h exp=%h", k, obs, exp_q[0]);
            end
            @(posedge clk); #1 idle_inputs();
        end
    endtask

    task automatic test_interrupt();
        for (int k = 0; k < 6; k++) begin
            int j;
            rand_cp0();
            mtc0_noise();
            if (k == 0) begin
                cp0_status = 32'h0000_0401; hw_int = 6'b000001;
                exc_pc = 32'h8000_0100; in_delay_slot = 1'b0;
            end else begin
                j = $urandom_range(0, 5);
                hw_int = 6'($urandom); hw_int[j] = 1'b1;
                cp0_status[0] = 1'b1; cp0_status[1] = 1'b0; cp0_status[10 + j] = 1'b1;
            end
            inst_valid = 1'b1;
            build_expected();
            foreach (exp_q[i]) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL irq k=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                @(posedge clk); #1 mtc0_noise();
            end
            idle_inputs();
        end
    endtask

    task automatic test_syscall();
        for (int k = 0; k < 6; k++) begin
            rand_cp0();
            mtc0_noise();
            if (k == 0) begin
                exc_pc = 32'h8000_0204; in_delay_slot = 1'b1;
            end else if (k == 1) begin
                exc_pc = 32'h0000_0000; in_delay_slot = 1'b1;
            end
            cp0_status[1] = 1'b0;
            hw_int = 6'd0;
            inst_valid = 1'b1; exc_syscall = 1'b1; exc_eret = 1'($urandom_range(0, 1));
            build_expected();
            foreach (exp_q[i]) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL syscall k=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                @(posedge clk); #1 mtc0_noise();
            end
            idle_inputs();
        end
    endtask

    task automatic test_eret();
        for (int k = 0; k < 6; k++) begin
            rand_cp0();
            mtc0_noise();
            if (k == 0) begin
                cp0_status = 32'h0000_0403; cp0_epc = 32'h8000_0104;
            end
            cp0_status[1] = 1'b1;
            inst_valid = 1'b1; exc_eret = 1'b1; hw_int = 6'($urandom);
            build_expected();
            foreach (exp_q[i]) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL eret k=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                @(posedge clk); #1 mtc0_noise();
            end
            idle_inputs();
        end
    endtask

    // Handler-level behaviour: nested syscall skips EPC; interrupts masked by EXL.
    task automatic test_exl();
        for (int k = 0; k < 4; k++) begin
            rand_cp0();
            mtc0_noise();
            cp0_status[1] = 1'b1;
            inst_valid = 1'b1; exc_syscall = 1'b1; hw_int = 6'($urandom);
            build_expected();
            foreach (exp_q[i]) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL nested_sys k=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                @(posedge clk); #1 mtc0_noise();
            end
            idle_inputs();
        end
        rand_cp0();
        cp0_status[1:0] = 2'b11; cp0_status[15:10] = 6'h3F;
        inst_valid = 1'b1; hw_int = 6'h3F;
        for (int k = 0; k < 4; k++) begin
            mtc0_noise();
            build_expected();
            @(negedge clk);
            checks++;
            if (obs !== exp_q[0]) begin
                failures++; $display("FAIL masked_irq k=%0d got=%h exp=%h", k, obs, exp_q[0]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        rand_cp0();
        cp0_status[1] = 1'b0;
        inst_valid = 1'b1; exc_syscall = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (!cp0_we || cp0_waddr !== 5'd13) begin
            failures++; $display("FAIL mid_in_cause got we=%b addr=%0d exp we=1 addr=13",
                                 cp0_we, cp0_waddr);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 73'd0) begin
                failures++; $display("FAIL after_rst k=%0d got=%h exp=%h", k, obs, 73'd0);
            end
            @(posedge clk); #1;
        end
        rand_cp0();
        cp0_status[1] = 1'b0;
        inst_valid = 1'b1; exc_syscall = 1'b1;
        build_expected();
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++; $display("FAIL post_rst_sys cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // Random mix, each event presented the cycle after the previous one returns to idle.
    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            rand_cp0();
            mtc0_noise();
            hw_int = 6'($urandom);
            inst_valid = ($urandom_range(0, 3) != 0);
            exc_syscall = ($urandom_range(0, 2) == 0);
            exc_eret = ($urandom_range(0, 2) == 0);
            build_expected();
            foreach (exp_q[i]) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b k=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_q[i]);
                end
                @(posedge clk); #1 mtc0_noise();
            end
            idle_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_mtc0_passthrough();
        test_interrupt();
        test_syscall();
        test_eret();
        test_exl();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt controller that sequences the CP0 register file for the MIPS32 pipeline. Detects hardware interrupts, SYSCALL and ERET at the MEM stage, and shares the single CP0 write port between pipeline MTC0 writes and its own multi-cycle EPC/Cause/Status update sequence. When a sequence ends, it issues a pipeline flush and a redirect PC.

## Interface
- VECTOR_OFFSET, 32'h0000_0180, offset added to EBase to form the exception entry PC
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- hw_int  input  6  hardware interrupt lines (IP7..IP2)
- inst_valid  input  1  a valid, non-bubble instruction occupies MEM
- exc_syscall  input  1  MEM instruction is SYSCALL
- exc_eret  input  1  MEM instruction is ERET
- exc_pc  input  32  PC of the MEM instruction
- in_delay_slot  input  1  MEM instruction is in a branch delay slot
- mtc0_we  input  1  pipeline MTC0 write request
- mtc0_addr  input  5  MTC0 target register
- mtc0_data  input  32  MTC0 data
- cp0_status, cp0_cause, cp0_epc, cp0_ebase  input  32 each  current CP0 register values
- cp0_we  output  1  CP0 write enable
- cp0_waddr  output  5  CP0 write address
- cp0_wdata  output  32  CP0 write data
- stall  output  1  freeze IF..MEM
- flush  output  1  one-cycle pipeline flush
- new_pc_valid  output  1  one-cycle redirect strobe
- new_pc  output  32  redirect target

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
- int_pend = inst_valid & status[0] (IE) & ~status[1] (EXL) & |(hw_int & status[15:10]).
- Event priority in IDLE: int_pend > (inst_valid & exc_syscall) > (inst_valid & exc_eret). Latch exc_pc, in_delay_slot and ExcCode (interrupt 5'd0, syscall 5'd8) on the event.
- Interrupt/syscall: IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE. If status[1]=1 at detection (syscall inside a handler), skip W_EPC: IDLE -> W_CAUSE.
- ERET: IDLE -> W_STATUS -> REDIRECT -> IDLE.
- W_EPC: waddr=14, wdata = in_delay_slot ? exc_pc-4 : exc_pc (mod 2^32).
- W_CAUSE: waddr=13, wdata = {bd, cause[30:7], exccode, 2'b00}; bd = latched in_delay_slot when W_EPC was run, else cause[31].
- W_STATUS: waddr=12, wdata = status with bit1 set (exception) or cleared (ERET); other bits unchanged.
- REDIRECT: flush=1, new_pc_valid=1; new_pc = ebase + VECTOR_OFFSET (exception) or epc (ERET), using values sampled in this cycle.
- Write-port arbitration: in IDLE with no event, cp0_we/waddr/wdata pass through mtc0_* combinationally. In IDLE with an event, and in all other states, the sequencer owns the port. The same-cycle MTC0 is dropped because its instruction is flushed.
- Events presented while not IDLE are ignored; the pipeline is stalled and re-presents them.

## Timing
- Reset: state=IDLE, latched fields 0. Outputs from the next cycle: cp0_we=0, cp0_waddr=0, cp0_wdata=0, stall=0, flush=0, new_pc_valid=0, new_pc=0. Outputs in IDLE with no MTC0 and no event are the same.
- stall: combinational 1 in IDLE when an event is detected, and 1 in every non-IDLE state including REDIRECT.
- Event detected in cycle T: exception writes happen in T+1 (EPC), T+2 (Cause), T+3 (Status); flush/new_pc_valid in T+4. Total latency 4 cycles; 3 cycles when W_EPC is skipped.
- ERET detected in T: Status written in T+1, redirect in T+2.
- The redirect target is evaluated in REDIRECT, after the Status write has committed in CP0.
- rst during any state: next cycle IDLE; a partial sequence is abandoned with no flush.
- Interrupt and syscall in the same cycle: the interrupt wins, ExcCode=0, EPC=exc_pc of the syscall instruction.

## Test plan
- Reset, then idle with mtc0_we=1, addr=12, data=32'h1000_FC01 -> same-cycle cp0_we=1, waddr=12, wdata=32'h1000_FC01, stall=0.
- status=32'h0000_0401, hw_int=6'b000001, inst_valid=1, exc_pc=32'h8000_0100 -> stall at T. Then EPC=32'h8000_0100 at T+1, Cause ExcCode=0/BD=0 at T+2, Status=32'h0000_0403 at T+3, flush and new_pc=ebase+32'h180 at T+4.
- Syscall in delay slot, exc_pc=32'h8000_0204, status EXL=0 -> EPC wdata=32'h8000_0200, Cause bit31=1 with [6:2]=8.
- ERET with status=32'h0000_0403, epc=32'h8000_0104 -> Status wdata=32'h0000_0401 at T+1, new_pc=32'h8000_0104 with flush at T+2.
- Syscall with status EXL=1 -> no EPC write; Cause at T+1, Status at T+2, redirect at T+3. Interrupt masked (EXL=1) -> no action.
- Assert rst in W_CAUSE -> next cycle all outputs 0, no flush; a subsequent syscall runs a full sequence.
